// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared definitions for the scan sequencer: FSM state codes,
//               decoder enable patterns and slot count.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    // Number of decoder outputs being time-multiplexed.
    localparam int SLOT_COUNT = 8;

    // FSM state encoding (2 bits).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;

    // Decoder enable patterns, ordered {e1_n, e2_n, e3}.
    localparam logic [2:0] EN_ACTIVE   = 3'b001;
    localparam logic [2:0] EN_INACTIVE = 3'b110;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/next_slot_find.sv
`default_nettype none
// ============================================================================
// Module      : next_slot_find
// Description : Combinational slot search over an 8-bit mask.
//               Returns the next set index strictly above i_idx, and the
//               lowest set index of the whole mask.
// Ports       : i_mask      - slot mask (bit i = slot i enabled)
//               i_idx       - current slot index
//               o_next_idx  - next higher set index (valid when o_found)
//               o_found     - a higher set index exists
//               o_low_idx   - lowest set index (valid when o_nonzero)
//               o_nonzero   - mask has at least one bit set
// Revision    : 1.0 - initial release
// ============================================================================
module next_slot_find
    import scan_pkg::*;
(
    input  logic [SLOT_COUNT-1:0] i_mask,
    input  logic [2:0]            i_idx,
    output logic [2:0]            o_next_idx,
    output logic                  o_found,
    output logic [2:0]            o_low_idx,
    output logic                  o_nonzero
);

    // Both searches scan downward so that the last hit (lowest index) wins.
    always_comb begin
        o_next_idx = i_idx;
        o_found    = 1'b0;
        o_low_idx  = 3'd0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (i_mask[i] && (i > int'(i_idx))) begin
                o_next_idx = 3'(i);
                o_found    = 1'b1;
            end
            if (i_mask[i]) begin
                o_low_idx = 3'(i);
            end
        end
        o_nonzero = |i_mask;
    end

endmodule : next_slot_find
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_sequencer
// Description : Address/enable generator for a 74LS138-style 3-to-8 decoder.
//               Walks the slots selected in a latched mask, giving each slot
//               a blanking gap (enables off, address updated) followed by a
//               dwell (enables on, address frozen). All outputs registered.
// Ports       : clk            - clock, rising edge
//               reset          - synchronous active-high reset
//               i_start        - begin a pass (IDLE only)
//               i_stop         - abort a pass; wins over i_start
//               i_continuous   - loop passes when high at end of pass
//               i_slot_mask    - slots to include in a pass
//               o_a0..o_a2     - decoder address, o_a0 = LSB
//               o_e1_n, o_e2_n - active-low decoder enables
//               o_e3           - active-high decoder enable
//               o_busy         - high in BLANK and DWELL
//               o_slot_strobe  - pulse on first DWELL cycle of a slot
//               o_done         - pulse when a single pass completes
// Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_continuous,
    input  logic [SLOT_COUNT-1:0] i_slot_mask,
    output logic                  o_a0,
    output logic                  o_a1,
    output logic                  o_a2,
    output logic                  o_e1_n,
    output logic                  o_e2_n,
    output logic                  o_e3,
    output logic                  o_busy,
    output logic                  o_slot_strobe,
    output logic                  o_done
);

    // Counter reload values: the counter runs from N-1 down to 0, giving
    // exactly N cycles in each timed state.
    localparam logic [15:0] C_BLANK_LOAD = 16'(BLANK - 1);
    localparam logic [15:0] C_DWELL_LOAD = 16'(DWELL - 1);

    logic [1:0]            r_state;
    logic [15:0]           r_cnt;
    logic [SLOT_COUNT-1:0] r_mask;
    logic [2:0]            r_addr;
    logic [2:0]            r_en;
    logic                  r_busy;
    logic                  r_strobe;
    logic                  r_done;

    logic [1:0]            w_state_nxt;
    logic [15:0]           w_cnt_nxt;
    logic [SLOT_COUNT-1:0] w_mask_nxt;
    logic [2:0]            w_addr_nxt;
    logic                  w_strobe_nxt;
    logic                  w_done_nxt;

    // Next higher slot within the latched snapshot.
    logic [2:0]            w_next_idx;
    logic                  w_found;
    // Lowest slot of the live input mask, used when (re)latching.
    logic [2:0]            w_low_idx;
    logic                  w_nonzero;

    // Outputs of the finders that this design has no use for.
    logic [2:0]            w_unused_low;
    logic                  w_unused_nz;
    logic [2:0]            w_unused_next;
    logic                  w_unused_found;
    logic                  w_unused;

    next_slot_find u_find_snap (
        .i_mask     (r_mask),
        .i_idx      (r_addr),
        .o_next_idx (w_next_idx),
        .o_found    (w_found),
        .o_low_idx  (w_unused_low),
        .o_nonzero  (w_unused_nz)
    );

    next_slot_find u_find_live (
        .i_mask     (i_slot_mask),
        .i_idx      (r_addr),
        .o_next_idx (w_unused_next),
        .o_found    (w_unused_found),
        .o_low_idx  (w_low_idx),
        .o_nonzero  (w_nonzero)
    );

    assign w_unused = ^{w_unused_low, w_unused_nz, w_unused_next, w_unused_found};

    // Next-state logic. The address is only ever loaded on a transition
    // into BLANK, so it cannot change while the decoder is enabled.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mask_nxt   = r_mask;
        w_addr_nxt   = r_addr;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_mask_nxt = i_slot_mask;
                    if (w_nonzero) begin
                        w_addr_nxt  = w_low_idx;
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = C_BLANK_LOAD;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end

            ST_BLANK: begin
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 16'd0) begin
                    w_state_nxt  = ST_DWELL;
                    w_cnt_nxt    = C_DWELL_LOAD;
                    w_strobe_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end

            ST_DWELL: begin
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 16'd0) begin
                    if (w_found) begin
                        w_addr_nxt  = w_next_idx;
                        w_state_nxt = ST_BLANK;
                        w_cnt_nxt   = C_BLANK_LOAD;
                    end else if (i_continuous) begin
                        // Wrap: snapshot the live mask again. An empty mask
                        // ends the loop quietly, without a done pulse.
                        w_mask_nxt = i_slot_mask;
                        if (w_nonzero) begin
                            w_addr_nxt  = w_low_idx;
                            w_state_nxt = ST_BLANK;
                            w_cnt_nxt   = C_BLANK_LOAD;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 16'd0;
            r_mask   <= '0;
            r_addr   <= 3'd0;
            r_en     <= EN_INACTIVE;
            r_busy   <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mask   <= w_mask_nxt;
            r_addr   <= w_addr_nxt;
            r_en     <= (w_state_nxt == ST_DWELL) ? EN_ACTIVE : EN_INACTIVE;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_strobe <= w_strobe_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_a0          = r_addr[0];
    assign o_a1          = r_addr[1];
    assign o_a2          = r_addr[2];
    assign o_e1_n        = r_en[2];
    assign o_e2_n        = r_en[1];
    assign o_e3          = r_en[0];
    assign o_busy        = r_busy;
    assign o_slot_strobe = r_strobe;
    assign o_done        = r_done;

endmodule : scan_sequencer
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_sequencer
// Description : Self-checking bench for scan_sequencer (DWELL=4, BLANK=1).
//               Stimulus pushes expected strobe/done events (slot address
//               and cycle offset from the start edge) into a queue; a
//               monitor pops and compares whenever the DUT pulses
//               o_slot_strobe or o_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_sequencer;
    import scan_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start;
    logic       i_stop;
    logic       i_continuous;
    logic [7:0] i_slot_mask;
    logic       o_a0, o_a1, o_a2;
    logic       o_e1_n, o_e2_n, o_e3;
    logic       o_busy, o_slot_strobe, o_done;

    scan_sequencer #(.DWELL(4), .BLANK(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_continuous  (i_continuous),
        .i_slot_mask   (i_slot_mask),
        .o_a0          (o_a0),
        .o_a1          (o_a1),
        .o_a2          (o_a2),
        .o_e1_n        (o_e1_n),
        .o_e2_n        (o_e2_n),
        .o_e3          (o_e3),
        .o_busy        (o_busy),
        .o_slot_strobe (o_slot_strobe),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [2:0] addr;
        int         rel;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t0    = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] addr_now();
        return {o_a2, o_a1, o_a0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_strobe(input logic [2:0] a, input int rel);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.rel = rel;
        q.push_back(e);
    endtask

    task automatic push_done(input int rel);
        exp_t e;
        e.is_done = 1'b1; e.addr = 3'd0; e.rel = rel;
        q.push_back(e);
    endtask

    // Called at a negedge; the following posedge is edge 0 of the pass, so
    // cycle k of the pass is observed at the negedge where cyc - t0 == k.
    task automatic launch(input logic [7:0] mask, input logic cont);
        i_slot_mask  = mask;
        i_continuous = cont;
        i_start      = 1'b1;
        t0           = cyc;
        busy_cnt     = 0;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_en"},     32'({o_e1_n, o_e2_n, o_e3}), 32'(EN_INACTIVE));
        check({name, "_busy"},   32'(o_busy), 32'd0);
        check({name, "_done"},   32'(o_done), 32'd0);
        check({name, "_strobe"}, 32'(o_slot_strobe), 32'd0);
    endtask

    // Monitor / scoreboard
    logic       prev_act  = 1'b0;
    logic [2:0] prev_addr = 3'd0;

    always @(negedge clk) begin
        if (!reset) begin
            logic [2:0] en;
            exp_t       e;
            en = {o_e1_n, o_e2_n, o_e3};
            if (o_busy) busy_cnt++;
            if (en != EN_INACTIVE)
                check("en_group", 32'(en), 32'(EN_ACTIVE));
            if (en == EN_ACTIVE && prev_act)
                check("addr_stable", 32'(addr_now()), 32'(prev_addr));
            if (o_slot_strobe || o_done) begin
                if (q.size() == 0) begin
                    check("unexpected_event", {30'd0, o_done, o_slot_strobe}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("event_kind", 32'(o_done), 32'(e.is_done));
                    check("event_cycle", 32'(cyc - t0), 32'(e.rel));
                    if (!e.is_done) begin
                        check("strobe_addr", 32'(addr_now()), 32'(e.addr));
                        check("strobe_en", 32'(en), 32'(EN_ACTIVE));
                        check("strobe_busy", 32'(o_busy), 32'd1);
                    end else begin
                        check("done_busy", 32'(o_busy), 32'd0);
                    end
                end
            end
            prev_act  = (en == EN_ACTIVE);
            prev_addr = addr_now();
        end
    end

    initial begin
        reset        = 1'b1;
        i_start      = 1'b0;
        i_stop       = 1'b0;
        i_continuous = 1'b0;
        i_slot_mask  = 8'h00;

        // Reset for two cycles
        repeat (2) @(negedge clk);
        check("reset_addr", 32'(addr_now()), 32'd0);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Full mask, single pass
        for (int j = 0; j < 8; j++) push_strobe(3'(j), 2 + 5 * j);
        push_done(41);
        launch(8'hFF, 1'b0);
        drain(60);
        check("ff_busy_cycles", 32'(busy_cnt), 32'd40);

        // Sparse mask, mid-pass mask write ignored
        push_strobe(3'd2, 2);
        push_strobe(3'd5, 7);
        push_strobe(3'd7, 12);
        push_done(16);
        launch(8'hA4, 1'b0);
        repeat (4) @(negedge clk);
        i_slot_mask = 8'hFF;
        drain(30);
        check("a4_busy_cycles", 32'(busy_cnt), 32'd15);

        // Continuous: mask changed during first slot 7 takes effect at wrap
        push_strobe(3'd0, 2);
        push_strobe(3'd7, 7);
        push_strobe(3'd1, 12);
        push_strobe(3'd1, 17);
        push_strobe(3'd1, 22);
        launch(8'h81, 1'b1);
        repeat (7) @(negedge clk);          // cycle 8, inside slot 7 dwell
        i_slot_mask = 8'h02;
        repeat (15) @(negedge clk);         // cycle 23, dwell of third slot 1
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        i_continuous = 1'b0;
        check_idle_outputs("cont_stop");
        check("cont_stop_addr", 32'(addr_now()), 32'd1);
        repeat (8) @(negedge clk);
        check("cont_queue_empty", 32'(q.size()), 32'd0);

        // Stop in the 2nd dwell cycle of slot 3
        push_strobe(3'd3, 2);
        launch(8'h08, 1'b0);
        @(negedge clk);                     // cycle 2
        @(negedge clk);                     // cycle 3
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check_idle_outputs("stop");
        check("stop_addr", 32'(addr_now()), 32'd3);
        repeat (6) @(negedge clk);
        check("stop_no_done", 32'(q.size()), 32'd0);

        // Start and stop together in IDLE
        busy_cnt    = 0;
        i_slot_mask = 8'hFF;
        i_start     = 1'b1;
        i_stop      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_stop  = 1'b0;
        check_idle_outputs("startstop");
        repeat (10) @(negedge clk);
        check("startstop_busy_cycles", 32'(busy_cnt), 32'd0);

        // Zero mask
        push_done(1);
        launch(8'h00, 1'b0);
        drain(10);
        check("zero_busy_cycles", 32'(busy_cnt), 32'd0);

        // Reset in mid-dwell
        push_strobe(3'd6, 2);
        launch(8'h40, 1'b0);
        repeat (2) @(negedge clk);          // cycle 3
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_addr", 32'(addr_now()), 32'd0);
        check_idle_outputs("midreset");
        repeat (8) @(negedge clk);
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_scan_sequencer
`default_nettype wire

// File: doc/scan_sequencer.md
# scan_sequencer

Sequential address/enable generator that drives a 74LS138-style 3-to-8 decoder to time-multiplex eight loads (display digits or keypad rows). It steps through the slots enabled in a mask and holds each slot's address for a programmable dwell. Between slots it inserts a blanking gap with all decoder enables deasserted, so the address never changes while the decoder output is active. Outputs connect pin-for-pin to the decoder's `a0..a2`, `e1_n`, `e2_n` and `e3` inputs.

## Interface
- `DWELL`, default 4: cycles per slot with the decoder enabled; legal range 1..65535.
- `BLANK`, default 1: cycles per slot with the decoder disabled, before the dwell; legal range 1..65535.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: in IDLE, a high level sampled on an edge begins a pass; ignored while busy.
- `stop` in 1: abort; takes priority over `start`.
- `continuous` in 1: 1 = loop passes indefinitely; 0 = single pass. Sampled at each end of pass.
- `slot_mask` in 8: bit i = 1 includes slot i in the scan.
- `a0`, `a1`, `a2` out 1 each: slot address; `a0` is the LSB.
- `e1_n`, `e2_n` out 1 each: active-low decoder enables.
- `e3` out 1: active-high decoder enable.
- `busy` out 1: high in BLANK and DWELL.
- `slot_strobe` out 1: one-cycle pulse on the first DWELL cycle of each slot.
- `done` out 1: one-cycle pulse when a single pass completes normally.

## Operation
- All outputs are registered (Moore).
- Reset values:
  - `a2..a0` = 0.
  - `e1_n` = 1, `e2_n` = 1, `e3` = 0.
  - `busy`, `slot_strobe`, `done` = 0.
  - State = IDLE.
- Enable encoding:
  - Active: `e1_n` = 0, `e2_n` = 0, `e3` = 1.
  - Inactive: `e1_n` = 1, `e2_n` = 1, `e3` = 0. All three deassert together and always change together.
  - The enables are active only in DWELL.
- IDLE:
  - The address holds its last value; enables are inactive.
  - On `start` with `stop` = 0, latch `slot_mask` into the mask snapshot.
  - If the snapshot is nonzero, load the address with the lowest set index and go to BLANK.
  - If the snapshot is zero, stay in IDLE and pulse `done`.
- BLANK: enables inactive for exactly `BLANK` cycles, then go to DWELL.
- DWELL: enables active for exactly `DWELL` cycles. At the end of DWELL:
  - If a higher set index exists in the snapshot, load it into the address and go to BLANK.
  - Otherwise the pass ends. If `continuous` = 1, re-latch `slot_mask`:
    - If the new snapshot is nonzero, load its lowest set index and go to BLANK.
    - If it is zero, go to IDLE without pulsing `done`.
  - Otherwise (`continuous` = 0), go to IDLE and pulse `done`.
- Changes to `slot_mask` mid-pass are ignored; the snapshot is taken only at start and at each wrap.
- `stop` in BLANK or DWELL:
  - Next cycle: IDLE, enables inactive, `busy` = 0.
  - No `done` pulse; the address holds.
- `stop` in IDLE has no effect.
- `reset` overrides everything, in any state, on the next edge.

## Timing
- `start` sampled at edge 0: BLANK occupies cycles 1..`BLANK`, and DWELL occupies cycles `BLANK`+1..`BLANK`+`DWELL`.
- Per-slot period is `BLANK` + `DWELL` cycles.
- A single pass over k slots keeps `busy` high for k·(`BLANK`+`DWELL`) cycles.
- `done` is high in the first IDLE cycle after the pass.
- The address changes only on the first cycle of BLANK, never while enabled.
- Zero-mask `start` at edge 0 gives `done` = 1 in cycle 1.
- Internal dwell/blank counter: 16 bits, counting down, reloaded on each state entry.

## Structure
- Shared package `scan_pkg` holds:
  - State encoding: IDLE, BLANK, DWELL, 2 bits.
  - Enable constants `EN_ACTIVE` = {e1_n,e2_n,e3} = 3'b001 and `EN_INACTIVE` = 3'b110.
  - Slot count constant 8.
- Sub-module `next_slot_find` (combinational). Given an 8-bit mask and a 3-bit current index, it returns:
  - The next higher set index and a `found` flag.
  - The lowest set index and a `nonzero` flag.

## Test plan
All scenarios use the defaults `DWELL` = 4, `BLANK` = 1.
- Reset asserted for 2 cycles -> `a2..a0` = 0, `e1_n` = 1, `e2_n` = 1, `e3` = 0; `busy`, `done`, `slot_strobe` all 0.
- `slot_mask` = 8'hFF, `continuous` = 0, `start` pulse -> address 0..7, 5 cycles each, enabled for the last 4; 8 strobes; `busy` for 40 cycles; `done` in cycle 41.
- `slot_mask` = 8'hA4 -> slots 2, 5, 7 only; `done` in cycle 16. Writing 8'hFF mid-pass does not alter the sequence.
- `continuous` = 1, `slot_mask` = 8'h81 -> slots 0, 7, 0, 7. Mask changed to 8'h02 during the first slot 7 -> after the wrap the sequence is 1, 1, …; `done` never asserts.
- `stop` in the 2nd DWELL cycle of slot 3 -> next cycle enables inactive, `busy` = 0, `done` = 0. `start` and `stop` in the same IDLE cycle -> remains IDLE.
- `slot_mask` = 0, `start` -> `done` = 1 in cycle 1, `busy` never 1. `reset` in mid-DWELL -> all reset values on the next cycle.
